// File: rtl/OmpSsManager.sv
// OmpSsManager: header field positions, command/ack codes and FSM state type shared by the lock manager.
package OmpSsManager;
  localparam int CMD_TYPE_L = 0;
  localparam int CMD_TYPE_H = 7;
  localparam int LOCK_ID_L = 32;
  localparam int LOCK_ID_H = 39;
  localparam int LOCK_ID_BITS = LOCK_ID_H - LOCK_ID_L + 1;
  localparam logic [7:0] CMD_LOCK_CODE = 8'h04;
  localparam logic [7:0] CMD_UNLOCK_CODE = 8'h06;
  localparam logic [7:0] ACK_OK_CODE = 8'h01;
  localparam logic [7:0] ACK_REJECT_CODE = 8'h00;
  localparam logic [7:0] ACK_NOT_OWNER_CODE = 8'h02;
  typedef enum logic [1:0] {READ_HEADER, CHECK_LOCK, SEND_ACK} lock_state_t;
endpackage

// File: rtl/lock_manager_table.sv
// lock_table: held bits and owner per lock, combinational read, single synchronous write port.
module lock_table #(
  parameter int NUM_LOCKS = 4,
  parameter int ACC_BITS = 4,
  parameter int LIDX_BITS = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [LIDX_BITS-1:0] rd_idx,
  output logic                 rd_held,
  output logic [ACC_BITS-1:0]  rd_owner,
  input  logic                 wr_set,
  input  logic                 wr_clr,
  input  logic [LIDX_BITS-1:0] wr_idx,
  input  logic [ACC_BITS-1:0]  wr_owner,
  output logic [NUM_LOCKS-1:0] lock_status
);
  logic [NUM_LOCKS-1:0] locked;
  logic [NUM_LOCKS-1:0][ACC_BITS-1:0] owner;
  assign rd_held = locked[rd_idx];
  assign rd_owner = owner[rd_idx];
  assign lock_status = locked;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      locked <= '0;
      owner <= '0;
    end else if (wr_set) begin
      locked[wr_idx] <= 1'b1;
      owner[wr_idx] <= wr_owner;
    end else if (wr_clr) begin
      locked[wr_idx] <= 1'b0;
    end
  end
endmodule

// File: rtl/lock_manager.sv
// lock_manager: owner-checked multi-lock mutex service; LOCK_UNLOCK_ACK_EN makes every unlock return an ack.
module lock_manager
  import OmpSsManager::*;
#(
  parameter int MAX_ACCS = 16,
  parameter int NUM_LOCKS = 4,
  localparam int ACC_BITS = $clog2(MAX_ACCS),
  localparam int LIDX_BITS = NUM_LOCKS > 1 ? $clog2(NUM_LOCKS) : 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [63:0]          inStream_TDATA,
  input  logic                 inStream_TVALID,
  input  logic [ACC_BITS-1:0]  inStream_TID,
  output logic                 inStream_TREADY,
  output logic [63:0]          outStream_TDATA,
  output logic                 outStream_TVALID,
  input  logic                 outStream_TREADY,
  output logic                 outStream_TLAST,
  output logic [ACC_BITS-1:0]  outStream_TDEST,
  output logic [NUM_LOCKS-1:0] lock_status
);
  lock_state_t state, state_n;
  logic [ACC_BITS-1:0] acc_id, rd_owner;
  logic [7:0] cmd_type, ack_code, ack_n;
  logic [LOCK_ID_BITS-1:0] lock_id;
  logic [LIDX_BITS-1:0] lidx;
  logic in_range, rd_held, is_lock, is_unlock, granted, released, wr_set, wr_clr;
  logic unused_bits;
  assign unused_bits = ^{inStream_TDATA[63:LOCK_ID_H+1], inStream_TDATA[LOCK_ID_L-1:CMD_TYPE_H+1]};
  // out-of-range ids are steered to entry 0 and their read result is masked
  assign in_range = 32'(lock_id) < NUM_LOCKS;
  assign lidx = in_range ? lock_id[LIDX_BITS-1:0] : '0;
  assign is_lock = cmd_type == CMD_LOCK_CODE;
  assign is_unlock = cmd_type == CMD_UNLOCK_CODE;
  assign granted = is_lock && in_range && !rd_held;
  assign released = is_unlock && in_range && rd_held && rd_owner == acc_id;
  assign wr_set = state == CHECK_LOCK && granted;
  assign wr_clr = state == CHECK_LOCK && released;
  assign inStream_TREADY = state == READ_HEADER;
  assign outStream_TVALID = state == SEND_ACK;
  assign outStream_TDATA = {56'd0, ack_code};
  assign outStream_TDEST = acc_id;
  assign outStream_TLAST = 1'b1;
  lock_table #(.NUM_LOCKS(NUM_LOCKS), .ACC_BITS(ACC_BITS), .LIDX_BITS(LIDX_BITS)) u_table (
    .clk(clk), .rstn(rstn), .rd_idx(lidx), .rd_held(rd_held), .rd_owner(rd_owner),
    .wr_set(wr_set), .wr_clr(wr_clr), .wr_idx(lidx), .wr_owner(acc_id), .lock_status(lock_status)
  );
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= READ_HEADER;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    ack_n = ack_code;
    unique case (state)
      READ_HEADER: state_n = inStream_TVALID ? CHECK_LOCK : READ_HEADER;
      CHECK_LOCK: begin
        state_n = is_lock ? SEND_ACK : READ_HEADER;
        ack_n = is_lock ? (granted ? ACK_OK_CODE : ACK_REJECT_CODE) : ack_code;
`ifdef LOCK_UNLOCK_ACK_EN
        state_n = (is_lock || is_unlock) ? SEND_ACK : READ_HEADER;
        ack_n = is_unlock ? (released ? ACK_OK_CODE : ACK_NOT_OWNER_CODE) : ack_n;
`endif
      end
      SEND_ACK: state_n = outStream_TREADY ? READ_HEADER : SEND_ACK;
      default: state_n = READ_HEADER;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_id <= '0;
      cmd_type <= '0;
      lock_id <= '0;
      ack_code <= '0;
    end else begin
      ack_code <= ack_n;
      if (state == READ_HEADER && inStream_TVALID) begin
        acc_id <= inStream_TID;
        cmd_type <= inStream_TDATA[CMD_TYPE_H:CMD_TYPE_L];
        lock_id <= inStream_TDATA[LOCK_ID_H:LOCK_ID_L];
      end
    end
  end
endmodule

// File: tb/tb_lock_manager.sv
// tb_lock_manager: directed plan plus random commands against an array-based lock/owner model.
module tb_lock_manager;
  import OmpSsManager::*;
  localparam int NL = 4;
  logic clk = 0, rstn = 0;
  logic [63:0] in_data = '0;
  logic in_valid = 0, out_ready = 0;
  logic [3:0] in_tid = '0;
  logic in_ready, out_valid, out_last;
  logic [63:0] out_data;
  logic [3:0] out_dest;
  logic [NL-1:0] lock_status;
  int errors = 0, checks = 0;
  bit m_held [NL];
  int m_owner [NL];

  lock_manager #(.MAX_ACCS(16), .NUM_LOCKS(NL)) dut (
    .clk(clk), .rstn(rstn),
    .inStream_TDATA(in_data), .inStream_TVALID(in_valid), .inStream_TID(in_tid), .inStream_TREADY(in_ready),
    .outStream_TDATA(out_data), .outStream_TVALID(out_valid), .outStream_TREADY(out_ready),
    .outStream_TLAST(out_last), .outStream_TDEST(out_dest), .lock_status(lock_status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NL-1:0] m_status();
    logic [NL-1:0] s = '0;
    for (int i = 0; i < NL; i++) s[i] = m_held[i];
    return s;
  endfunction

  task automatic put(input int acc, input logic [7:0] cmd, input int id);
    logic [63:0] h;
    int n = 0;
    h = {$urandom, $urandom};
    h[CMD_TYPE_H:CMD_TYPE_L] = cmd;
    h[LOCK_ID_H:LOCK_ID_L] = 8'(id);
    in_data = h;
    in_tid = 4'(acc);
    in_valid = 1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic xact(input int acc, input logic [7:0] cmd, input int id, input int stall);
    bit ack = 0, rel;
    logic [7:0] code = '0;
    if (cmd == CMD_LOCK_CODE) begin
      ack = 1;
      if (id < NL && !m_held[id]) begin
        m_held[id] = 1;
        m_owner[id] = acc;
        code = ACK_OK_CODE;
      end else code = ACK_REJECT_CODE;
    end else if (cmd == CMD_UNLOCK_CODE) begin
      rel = id < NL && m_held[id] && m_owner[id] == acc;
      if (rel) m_held[id] = 0;
`ifdef LOCK_UNLOCK_ACK_EN
      ack = 1;
      code = rel ? ACK_OK_CODE : ACK_NOT_OWNER_CODE;
`endif
    end
    put(acc, cmd, id);
    chk("check_tready", 64'(in_ready), 0);
    @(negedge clk);
    chk("tvalid_latency", 64'(out_valid), 64'(ack));
    chk("lock_status", 64'(lock_status), 64'(m_status()));
    if (ack) begin
      chk("ack_data", out_data, {56'd0, code});
      chk("ack_dest", 64'(out_dest), 64'(acc));
      chk("ack_last", 64'(out_last), 1);
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        chk("stall_valid", 64'(out_valid), 1);
        chk("stall_data", out_data, {56'd0, code});
        chk("stall_dest", 64'(out_dest), 64'(acc));
        chk("stall_in_ready", 64'(in_ready), 0);
      end
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
      chk("post_ack_valid", 64'(out_valid), 0);
    end
    chk("ready_again", 64'(in_ready), 1);
  endtask

  initial begin
    int r, cmdsel;
    logic [7:0] cmd;
    for (int i = 0; i < NL; i++) begin m_held[i] = 0; m_owner[i] = 0; end
    #2;
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_dest", 64'(out_dest), 0);
    chk("rst_status", 64'(lock_status), 0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1;
    @(negedge clk);
    xact(3, CMD_LOCK_CODE, 2, 0);
    chk("first_status", 64'(lock_status), 64'b0100);
    xact(5, CMD_LOCK_CODE, 2, 0);
    xact(3, CMD_LOCK_CODE, 2, 0);
    xact(5, CMD_UNLOCK_CODE, 2, 0);
    chk("non_owner_unlock", 64'(lock_status), 64'b0100);
    xact(3, CMD_UNLOCK_CODE, 2, 0);
    chk("owner_unlock", 64'(lock_status), 0);
    xact(5, CMD_LOCK_CODE, 2, 0);
    xact(5, CMD_UNLOCK_CODE, 2, 0);
    xact(4, CMD_LOCK_CODE, 7, 0);
    chk("oor_lock", 64'(lock_status), 0);
    xact(4, CMD_UNLOCK_CODE, 7, 0);
    xact(6, CMD_LOCK_CODE, 1, 10);
    xact(2, 8'h5A, 1, 0);
    xact(6, CMD_UNLOCK_CODE, 1, 0);
    xact(1, CMD_LOCK_CODE, 0, 0);
    xact(9, CMD_LOCK_CODE, 3, 0);
    put(2, CMD_LOCK_CODE, 1);
    @(negedge clk);
    chk("pre_rst_valid", 64'(out_valid), 1);
    #2 rstn = 0;
    #1;
    chk("async_valid", 64'(out_valid), 0);
    chk("async_status", 64'(lock_status), 0);
    chk("async_in_ready", 64'(in_ready), 1);
    @(negedge clk);
    rstn = 1;
    for (int i = 0; i < NL; i++) m_held[i] = 0;
    @(negedge clk);
    for (int t = 0; t < 200; t++) begin
      cmdsel = $urandom_range(0, 9);
      cmd = cmdsel < 5 ? CMD_LOCK_CODE : cmdsel < 9 ? CMD_UNLOCK_CODE : 8'h5A;
      r = $urandom_range(0, 15);
      xact(r, cmd, $urandom_range(0, 5), $urandom_range(0, 2));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
